regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count, power of two, >= 2; register 0 reads as zero.
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports, 1..4.
REQ-004 SHALL define derived constant AW = clog2(NUM_REGS), register index width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  write strobe.
REQ-008 SHALL have port wr_num  input  AW  write register index.
REQ-009 SHALL have port wr_data  input  DATA_W  write data.
REQ-010 SHALL have port claim_en  input  1  mark register pending (producer issued).
REQ-011 SHALL have port claim_num  input  AW  register index to mark pending.
REQ-012 SHALL have port flush  input  1  clear all pending marks, data untouched.
REQ-013 SHALL have port rd_num  input  NRD x AW  read indices, one per port.
REQ-014 SHALL have port rd_data  output  NRD x DATA_W  read data, combinational.
REQ-015 SHALL have port rd_busy  output  NRD  read register pending, combinational.
REQ-016 SHALL have port busy_cnt  output  AW+1  registered count of pending registers.

Function
REQ-017 SHALL write wr_data into register wr_num on the clk rising edge when wr_en=1 and wr_num!=0; writes to index 0 ignored.
REQ-018 SHALL drive rd_data[i]=0 when rd_num[i]==0, regardless of wr/claim activity.
REQ-019 SHALL bypass: rd_data[i]=wr_data when wr_en=1, wr_num==rd_num[i], rd_num[i]!=0; else stored value (zero read latency).
REQ-020 SHALL keep one busy bit per register 1..NUM_REGS-1; busy bit for index 0 constant 0.
REQ-021 SHALL set busy[claim_num] at the edge when claim_en=1 and claim_num!=0.
REQ-022 SHALL clear busy[wr_num] at the edge when wr_en=1 and wr_num!=0, unless claimed same cycle.
REQ-023 SHALL give claim priority: wr_en and claim_en to same index same cycle -> data written, busy ends 1.
REQ-024 SHALL drive rd_busy[i]=busy[rd_num[i]] AND NOT (wr_en AND wr_num==rd_num[i]); rd_busy ignores same-cycle claim.
REQ-025 SHALL clear all busy bits at the edge when flush=1; flush overrides a same-cycle claim; a same-cycle write still updates data.
REQ-026 SHALL keep busy_cnt equal to popcount of busy bits after each edge; range 0..NUM_REGS-1, never wraps.
REQ-027 SHALL leave busy unchanged on a write to a non-busy register and on a claim of an already-busy register.
REQ-028 SHALL serve all NRD read ports independently; identical indices on several ports return identical values.

Reset
REQ-029 SHALL, at the edge with rst=1, clear all data registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-030 SHALL give rst priority over wr_en, claim_en and flush in the same cycle; those inputs are discarded.
REQ-031 SHALL present rd_data=0 and rd_busy=0 on all ports from the first cycle after reset, absent writes.

Structure
REQ-032 SHALL place DATA_W/NUM_REGS defaults and the AW derivation in shared package cpu_pkg.
REQ-033 SHALL use one sub-module, regfile_sb_scoreboard, holding busy bits, priority logic and busy_cnt.
REQ-034 SHALL implement read ports via a generate loop over NRD, no per-port hand copies.

Verification
REQ-035 SHALL cover: reset, then read r0..r31 on all ports -> all rd_data=0, rd_busy=0, busy_cnt=0.
REQ-036 SHALL cover: write r5=0xDEADBEEF while rd_num[0]=5 -> rd_data[0]=0xDEADBEEF same cycle, and next cycle without write.
REQ-037 SHALL cover: write r0=0xFFFFFFFF, claim r0 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-038 SHALL cover: claim r3 -> next cycle rd_busy(r3)=1, busy_cnt=1; write r3=0x12 -> rd_busy=0 same cycle, busy_cnt=0 next.
REQ-039 SHALL cover: r7 busy, write and claim r7 same cycle -> r7=new data, busy stays 1, busy_cnt=1.
REQ-040 SHALL cover: claim r1..r31 over 31 cycles -> busy_cnt=31; flush with claim r2 -> busy_cnt=0; rst mid-sequence -> data and count zero.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared register-file sizing defaults and index-width helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  // Index width for a register count; a 1-bit index is the floor.
  function automatic int calc_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF = calc_aw(NUM_REGS_DEF);

  // Next-state action applied to a single busy bit
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_CLEAR = 2'd1,
    SB_SET   = 2'd2
  } sb_op_e;

endpackage

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// ============================================================================
//  Module   : regfile_sb_scoreboard
//  Brief    : Per-register pending bits with flush > claim > write priority
//             and a registered count of pending registers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sb_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int AW       = calc_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_num,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_num,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW-1:0] c_zero_idx = '0;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [AW:0]         r_cnt;
  logic [AW:0]         w_cnt_nxt;
  logic                w_wr_act;
  logic                w_cl_act;

  assign w_wr_act = wr_en    && (wr_num    != c_zero_idx);
  assign w_cl_act = claim_en && (claim_num != c_zero_idx);

  assign w_busy_nxt[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
    sb_op_e w_op;

    always_comb begin
      w_op = SB_HOLD;
      if (flush) begin
        w_op = SB_CLEAR;
      end else if (w_cl_act && (claim_num == AW'(gi))) begin
        w_op = SB_SET;
      end else if (w_wr_act && (wr_num == AW'(gi))) begin
        w_op = SB_CLEAR;
      end
    end

    assign w_busy_nxt[gi] = (w_op == SB_SET) | ((w_op == SB_HOLD) & r_busy[gi]);
  end

  // Count is taken from the next state so it lines up with the busy bits.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Register file with zero register, write-to-read bypass,
//             NRD combinational read ports and a pending-register scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sb
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NRD      = 2,
  localparam int AW       = calc_aw(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_num,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      claim_en,
  input  logic [AW-1:0]             claim_num,
  input  logic                      flush,
  input  logic [NRD-1:0][AW-1:0]    rd_num,
  output logic [NRD-1:0][DATA_W-1:0] rd_data,
  output logic [NRD-1:0]            rd_busy,
  output logic [AW:0]               busy_cnt
);

  localparam logic [AW-1:0] c_zero_idx = '0;

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && (wr_num != c_zero_idx)) begin
      r_mem[wr_num] <= wr_data;
    end
  end

  regfile_sb_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_num    (wr_num),
    .claim_en  (claim_en),
    .claim_num (claim_num),
    .flush     (flush),
    .busy      (w_busy),
    .busy_cnt  (busy_cnt)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic              w_hit;
    logic              w_is_zero;
    logic [DATA_W-1:0] w_data;

    assign w_is_zero = (rd_num[gi] == c_zero_idx);
    assign w_hit     = wr_en && (wr_num == rd_num[gi]);

    // A same-cycle write both forwards its data and retires the pending mark.
    assign w_data      = w_is_zero ? '0 : (w_hit ? wr_data : r_mem[rd_num[gi]]);
    assign rd_data[gi] = w_data;
    assign rd_busy[gi] = w_busy[rd_num[gi]] & ~w_hit;
  end

endmodule

`default_nettype wire
